fetch_unit: RTL and testbench

- Instruction-fetch stage of the RV32I core, directly upstream of the control unit and datapath.
- Owns the architectural PC and issues one outstanding request at a time to a variable-latency instruction memory over a valid/ready handshake.
- Presents `inst`, `pc` and `pc_plus4` with a valid flag to decode and execute.
- Computes the next PC from the branch/jump decision (`pcmux_sel`, `alu_out`) returned by decode/execute when the instruction retires.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_next_pc_sel.sv | 38 +++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I front end: fetch FSM states, the canonical
// NOP, the reset PC default and a word-alignment helper.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  // Clearing the low two bits also covers the JALR rule of ignoring bit 0.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and
// a variable-latency instruction memory.
interface fetch_unit_if;
  import rv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential increment, aligned branch/jump
// redirect, external flush (highest priority) and the misaligned-target flag.
module next_pc_sel
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            retire,
  input  logic            pcmux_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_load,
  output logic            misalign
);

  logic [XLEN-1:0] redirect_pc;

  assign pc_plus4    = pc + XLEN'(4);
  assign redirect_pc = word_align(alu_out);

  // A flush overrides whatever the retiring instruction asked for.
  always_comb begin
    pc_next  = pc;
    pc_load  = 1'b0;
    misalign = 1'b0;
    if (flush_valid) begin
      pc_next = word_align(flush_pc);
      pc_load = 1'b1;
    end else if (retire) begin
      pc_load  = 1'b1;
      pc_next  = pcmux_sel ? redirect_pc : pc_plus4;
      misalign = pcmux_sel & alu_out[1];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one request outstanding to instruction
// memory and holds the fetched instruction until downstream retires it.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_unit_if.master     imem,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             pcmux_sel,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             flush_valid,
  input  logic [XLEN-1:0]  flush_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            drop_pending;
  logic            drop_next;
  logic            valid_next;
  logic            inst_load;
  logic            retire;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic            misalign;

  assign imem.imem_req_addr = pc;

  next_pc_sel u_next_pc_sel (
    .pc          (pc),
    .retire      (retire),
    .pcmux_sel   (pcmux_sel),
    .alu_out     (alu_out),
    .flush_valid (flush_valid),
    .flush_pc    (flush_pc),
    .pc_plus4    (pc_plus4),
    .pc_next     (pc_next),
    .pc_load     (pc_load),
    .misalign    (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_BOOT;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_next;
      drop_pending <= drop_next;
    end
  end

  // drop_pending marks an outstanding request whose response belongs to a
  // PC that a flush has since abandoned.
  always_comb begin
    state_next = state;
    drop_next  = drop_pending;
    valid_next = inst_valid;
    inst_load  = 1'b0;
    retire     = 1'b0;
    case (state)
      S_BOOT: state_next = S_REQ;
      S_REQ: begin
        if (imem.imem_req_ready) begin
          state_next = S_WAIT;
          drop_next  = flush_valid;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          drop_next = 1'b0;
          if (drop_pending || flush_valid) begin
            state_next = S_REQ;
          end else begin
            state_next = S_HOLD;
            inst_load  = 1'b1;
            valid_next = 1'b1;
          end
        end else if (flush_valid) begin
          drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_valid) begin
          state_next = S_REQ;
          valid_next = 1'b0;
        end else if (inst_ready) begin
          state_next = S_REQ;
          valid_next = 1'b0;
          retire     = 1'b1;
        end
      end
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                  <= word_align(RESET_PC);
      inst                <= NOP_INST;
      inst_valid          <= 1'b0;
      imem.imem_req_valid <= 1'b0;
      misalign_err        <= 1'b0;
      retire_count        <= '0;
    end else begin
      if (pc_load) begin
        pc <= pc_next;
      end
      if (inst_load) begin
        inst <= imem.imem_rsp_data;
      end
      inst_valid          <= valid_next;
      imem.imem_req_valid <= (state_next == S_REQ);
      misalign_err        <= misalign;
      if (retire) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed handshake sequences, a table of
// retire/redirect/flush vectors and a randomized run against a transaction model.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int CNT_W = 32;
  localparam int TMO   = 200;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [31:0]      inst;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             inst_valid;
  logic             inst_ready;
  logic             pcmux_sel;
  logic [31:0]      alu_out;
  logic             flush_valid;
  logic [31:0]      flush_pc;
  logic             misalign_err;
  logic [CNT_W-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  fetch_unit_if imem_bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus),
    .inst         (inst),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .pcmux_sel    (pcmux_sel),
    .alu_out      (alu_out),
    .flush_valid  (flush_valid),
    .flush_pc     (flush_pc),
    .misalign_err (misalign_err),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [31:0] alu,
                               input logic flush, input logic [31:0] fpc,
                               input logic ready);
    pcmux_sel   = sel;
    alu_out     = alu;
    flush_valid = flush;
    flush_pc    = fpc;
    inst_ready  = ready;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_inst_valid(input string name);
    int n = 0;
    while (inst_valid !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_valid_seen"}, inst_valid, 1);
  endtask

  task automatic wait_req_valid(input string name);
    int n = 0;
    while (imem_bus.imem_req_valid !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_req_seen"}, imem_bus.imem_req_valid, 1);
  endtask

  // Instruction memory model: auto mode answers with programmable or random
  // delays; manual mode leaves the channel to the directed sequences.
  logic        mem_auto = 1'b1;
  logic        mem_rand = 1'b0;
  int          ready_delay = 0;
  int          rsp_delay   = 1;
  logic        acc_evt;
  logic [31:0] acc_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_evt <= 1'b0;
    end else begin
      acc_evt  <= imem_bus.imem_req_valid && imem_bus.imem_req_ready;
      acc_addr <= imem_bus.imem_req_addr;
    end
  end

  initial begin : mem_proc
    int          wait_cnt;
    int          cur_delay;
    int          rsp_cnt;
    logic        pend;
    logic [31:0] pend_addr;
    wait_cnt  = 0;
    cur_delay = 0;
    rsp_cnt   = 0;
    pend      = 1'b0;
    pend_addr = '0;
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!mem_auto || !rst_n) begin
        pend     = 1'b0;
        wait_cnt = 0;
        if (mem_auto) begin
          imem_bus.imem_req_ready = 1'b0;
          imem_bus.imem_rsp_valid = 1'b0;
        end
      end else begin
        imem_bus.imem_rsp_valid = 1'b0;
        if (acc_evt) begin
          pend      = 1'b1;
          pend_addr = acc_addr;
          rsp_cnt   = mem_rand ? int'($urandom_range(1, 4)) : rsp_delay;
        end
        if (pend) begin
          rsp_cnt--;
          if (rsp_cnt <= 0) begin
            imem_bus.imem_rsp_valid = 1'b1;
            imem_bus.imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
          end
        end
        if (imem_bus.imem_req_valid) begin
          if (wait_cnt == 0) begin
            cur_delay = mem_rand ? int'($urandom_range(0, 3)) : ready_delay;
          end
          imem_bus.imem_req_ready = (wait_cnt >= cur_delay);
          wait_cnt++;
        end else begin
          imem_bus.imem_req_ready = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  // Transaction-level reference: tracks the architectural PC, the held
  // instruction, whether a request is outstanding and whether its answer is stale.
  logic             m_boot;
  logic             m_valid;
  logic             m_out;
  logic             m_drop;
  logic             m_mis;
  logic             m_req;
  logic [31:0]      m_pc;
  logic [31:0]      m_inst;
  logic [CNT_W-1:0] m_cnt;

  assign m_req = !m_boot && !m_valid && !m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot  <= 1'b1;
      m_valid <= 1'b0;
      m_out   <= 1'b0;
      m_drop  <= 1'b0;
      m_mis   <= 1'b0;
      m_pc    <= 32'h0;
      m_inst  <= NOP_INST;
      m_cnt   <= '0;
    end else begin
      m_boot <= 1'b0;
      m_mis  <= 1'b0;
      if (flush_valid) begin
        m_pc    <= flush_pc & ~32'h3;
        m_valid <= 1'b0;
        if (m_req && imem_bus.imem_req_ready) begin
          m_out  <= 1'b1;
          m_drop <= 1'b1;
        end else if (m_out) begin
          if (imem_bus.imem_rsp_valid) begin
            m_out  <= 1'b0;
            m_drop <= 1'b0;
          end else begin
            m_drop <= 1'b1;
          end
        end
      end else begin
        if (m_req && imem_bus.imem_req_ready) m_out <= 1'b1;
        if (m_out && imem_bus.imem_rsp_valid) begin
          m_out  <= 1'b0;
          m_drop <= 1'b0;
          if (!m_drop) begin
            m_valid <= 1'b1;
            m_inst  <= imem_bus.imem_rsp_data;
          end
        end
        if (m_valid && inst_ready) begin
          m_valid <= 1'b0;
          m_cnt   <= m_cnt + 1;
          m_mis   <= pcmux_sel && alu_out[1];
          m_pc    <= pcmux_sel ? (alu_out & ~32'h3) : m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("mdl_inst_valid", inst_valid, m_valid);
      checkOutput("mdl_req_valid", imem_bus.imem_req_valid, m_req);
      if (m_req) checkOutput("mdl_req_addr", imem_bus.imem_req_addr, m_pc);
      checkOutput("mdl_pc", pc, m_pc);
      checkOutput("mdl_pc_plus4", pc_plus4, m_pc + 32'd4);
      checkOutput("mdl_retire_count", retire_count, m_cnt);
      checkOutput("mdl_misalign", misalign_err, m_mis);
      if (m_valid) checkOutput("mdl_inst", inst, m_inst);
    end
  end

  typedef struct {
    logic        sel;
    logic [31:0] alu;
    logic        flush;
    logic [31:0] fpc;
    logic [31:0] exp_addr;
    logic        exp_mis;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0000_0004, 1'b0, 32'd1};
    vecs[1] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0000_0100, 1'b0, 32'd2};
    vecs[2] = '{1'b1, 32'h0000_0203, 1'b0, 32'h0,         32'h0000_0200, 1'b1, 32'd3};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0000_0204, 1'b0, 32'd4};
    vecs[4] = '{1'b1, 32'h0000_0041, 1'b0, 32'h0,         32'h0000_0040, 1'b0, 32'd5};
    vecs[5] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 32'h0000_0080, 1'b0, 32'd5};
    vecs[6] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'd6};
    vecs[7] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 32'd7};
    vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 32'h8000_0003, 32'h8000_0000, 1'b0, 32'd7};
    vecs[9] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h8000_0004, 1'b0, 32'd8};

    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    begin : t1_zero_wait
      int   n_req;
      int   n_val;
      int   last_val;
      logic prev_req;
      n_req    = 0;
      n_val    = 0;
      last_val = -1;
      prev_req = 1'b0;
      inst_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && n_val < 3; cyc++) begin
        @(negedge clk);
        if (imem_bus.imem_req_valid && !prev_req) begin
          checkOutput($sformatf("t1_addr%0d", n_req), imem_bus.imem_req_addr, n_req * 4);
          n_req++;
        end
        prev_req = imem_bus.imem_req_valid;
        if (inst_valid) begin
          if (last_val >= 0) checkOutput("t1_interval", cyc - last_val, 3);
          last_val = cyc;
          n_val++;
        end
      end
      checkOutput("t1_nvalid", n_val, 3);
      @(negedge clk);
      checkOutput("t1_count", retire_count, 3);
      inst_ready = 1'b0;
    end

    begin : t2_slow_mem
      logic [31:0] a0;
      int          n_req;
      ready_delay = 4;
      rsp_delay   = 5;
      do_reset();
      wait_req_valid("t2");
      a0    = imem_bus.imem_req_addr;
      n_req = 0;
      while (imem_bus.imem_req_valid && n_req < TMO) begin
        checkOutput("t2_addr_stable", imem_bus.imem_req_addr, a0);
        n_req++;
        @(negedge clk);
      end
      checkOutput("t2_req_cycles", n_req, 5);
      wait_inst_valid("t2");
      checkOutput("t2_inst", inst, mem_word(32'h0));
      checkOutput("t2_pc", pc, 32'h0);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        checkOutput("t2_hold_valid", inst_valid, 1);
        checkOutput("t2_hold_inst", inst, mem_word(32'h0));
        checkOutput("t2_hold_pc", pc, 32'h0);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      checkOutput("t2_valid_clear", inst_valid, 0);
      checkOutput("t2_count", retire_count, 1);
    end

    begin : t4_flush_wait
      mem_auto    = 1'b0;
      ready_delay = 0;
      rsp_delay   = 1;
      imem_bus.imem_req_ready = 1'b0;
      imem_bus.imem_rsp_valid = 1'b0;
      do_reset();
      wait_req_valid("t4a");
      imem_bus.imem_req_ready = 1'b1;
      @(negedge clk);
      imem_bus.imem_req_ready = 1'b0;
      checkOutput("t4_in_wait", imem_bus.imem_req_valid, 0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      @(negedge clk);
      flush_valid = 1'b0;
      @(negedge clk);
      imem_bus.imem_rsp_valid = 1'b1;
      imem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_bus.imem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checkOutput("t4_dropped_valid", inst_valid, 0);
        checkOutput("t4_refetch_req", imem_bus.imem_req_valid, 1);
        checkOutput("t4_refetch_addr", imem_bus.imem_req_addr, 32'h8000_0000);
        @(negedge clk);
      end
      imem_bus.imem_req_ready = 1'b1;
      @(negedge clk);
      imem_bus.imem_req_ready = 1'b0;
      imem_bus.imem_rsp_valid = 1'b1;
      imem_bus.imem_rsp_data  = 32'h1234_5678;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      @(negedge clk);
      imem_bus.imem_rsp_valid = 1'b0;
      flush_valid = 1'b0;
      checkOutput("t4_coincide_valid", inst_valid, 0);
      checkOutput("t4_coincide_req", imem_bus.imem_req_valid, 1);
      checkOutput("t4_coincide_addr", imem_bus.imem_req_addr, 32'h8000_0000);
      imem_bus.imem_req_ready = 1'b1;
      @(negedge clk);
      imem_bus.imem_req_ready = 1'b0;
      imem_bus.imem_rsp_valid = 1'b1;
      imem_bus.imem_rsp_data  = 32'h00A0_0093;
      @(negedge clk);
      imem_bus.imem_rsp_valid = 1'b0;
      checkOutput("t4_final_valid", inst_valid, 1);
      checkOutput("t4_final_inst", inst, 32'h00A0_0093);
      checkOutput("t4_final_pc", pc, 32'h8000_0000);
      checkOutput("t4_final_pc_plus4", pc_plus4, 32'h8000_0004);
      mem_auto = 1'b1;
    end

    begin : t_table
      do_reset();
      for (int i = 0; i < 10; i++) begin
        wait_inst_valid($sformatf("tbl%0d", i));
        applyStimulus(vecs[i].sel, vecs[i].alu, vecs[i].flush, vecs[i].fpc, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput($sformatf("tbl%0d_req_valid", i), imem_bus.imem_req_valid, 1);
        checkOutput($sformatf("tbl%0d_req_addr", i), imem_bus.imem_req_addr, vecs[i].exp_addr);
        checkOutput($sformatf("tbl%0d_misalign", i), misalign_err, vecs[i].exp_mis);
        checkOutput($sformatf("tbl%0d_count", i), retire_count, vecs[i].exp_cnt);
        checkOutput($sformatf("tbl%0d_valid_clear", i), inst_valid, 0);
        @(negedge clk);
        checkOutput($sformatf("tbl%0d_misalign_end", i), misalign_err, 0);
        wait_inst_valid($sformatf("tbl%0d_next", i));
        checkOutput($sformatf("tbl%0d_pc", i), pc, vecs[i].exp_addr);
        checkOutput($sformatf("tbl%0d_pc_plus4", i), pc_plus4, vecs[i].exp_addr + 32'd4);
      end
    end

    begin : t6_reset_in_wait
      rsp_delay  = 3;
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      wait_req_valid("t6");
      @(negedge clk);
      checkOutput("t6_in_wait", imem_bus.imem_req_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", inst_valid, 0);
      checkOutput("t6_rst_req", imem_bus.imem_req_valid, 0);
      checkOutput("t6_rst_pc", pc, 32'h0);
      checkOutput("t6_rst_pc_plus4", pc_plus4, 32'h4);
      checkOutput("t6_rst_inst", inst, NOP_INST);
      checkOutput("t6_rst_count", retire_count, 0);
      checkOutput("t6_rst_misalign", misalign_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_req_valid("t6_after");
      checkOutput("t6_first_addr", imem_bus.imem_req_addr, 32'h0);
    end

    begin : t_random
      do_reset();
      mem_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
        applyStimulus(1'($urandom_range(0, 1)), $urandom,
                      ($urandom_range(0, 15) == 0), $urandom,
                      1'($urandom_range(0, 1)));
        @(negedge clk);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("rand_progress", (retire_count > 10), 1);
      mem_rand = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
